// File: rtl/cve2_imem_pkg.sv
// Shared types and address-window helpers for the instruction memory responder.
// The window test masks the byte offset so fetches are always word aligned.
package cve2_imem_pkg;

    typedef enum logic {
        GntIdle,
        GntWait
    } gnt_state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } imem_entry_t;

    function automatic logic [31:0] win_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr & 32'hFFFF_FFFC) - base;
    endfunction

    // Unsigned wrap-around subtraction makes addresses below the base fall out of range.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        return win_offset(addr, base) < (words * 4);
    endfunction

endpackage

// File: rtl/cve2_imem_resp_pipe.sv
// Fixed-latency response pipeline: each stage carries {valid, err}; stage 1 takes
// its data straight from the SRAM output, later stages register it.
module cve2_imem_resp_pipe
    import cve2_imem_pkg::*;
#(
    parameter int unsigned RvalidLat = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic        in_err_i,
    input  logic [31:0] mem_rdata_i,
    output imem_entry_t rsp_o
);

    logic [RvalidLat-1:0] stage_vld;
    logic [RvalidLat-1:0] stage_err;
    logic [31:0]          stage_rdata [RvalidLat];

    for (genvar i = 0; i < RvalidLat; i++) begin : g_stage
        logic v_q, e_q;
        logic v_d, e_d;

        if (i == 0) begin : g_first
            assign v_d            = in_valid_i;
            assign e_d            = in_err_i;
            assign stage_rdata[0] = e_q ? '0 : mem_rdata_i;
        end else begin : g_later
            logic [31:0] d_q;
            assign v_d = stage_vld[i-1];
            assign e_d = stage_err[i-1];
            always_ff @(posedge clk_i) begin
                d_q <= stage_rdata[i-1];
            end
            assign stage_rdata[i] = d_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                e_q <= 1'b0;
            end else begin
                v_q <= v_d;
                e_q <= e_d;
            end
        end

        assign stage_vld[i] = v_q;
        assign stage_err[i] = e_q;
    end

    always_comb begin
        rsp_o.valid = stage_vld[RvalidLat-1];
        rsp_o.err   = stage_vld[RvalidLat-1] & stage_err[RvalidLat-1];
        rsp_o.rdata = stage_vld[RvalidLat-1] ? stage_rdata[RvalidLat-1] : '0;
    end

endmodule

// File: rtl/cve2_imem_responder.sv
// Instruction-fetch responder: grant FSM with programmable wait states, outstanding
// tracking, and a fixed-latency response pipeline in front of a synchronous SRAM.
module cve2_imem_responder
    import cve2_imem_pkg::*;
#(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RvalidLat      = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic [1:0]                  gnt_wait_i,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        busy_o
);

    localparam int unsigned AddrW = $clog2(MemWords);
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    gnt_state_e      state_q, state_d;
    logic [1:0]      wait_cnt_q;
    logic [OutW-1:0] out_cnt_q;
    logic            gnt;
    logic            in_range;
    logic            rvalid;
    imem_entry_t     rsp;

    assign in_range = in_window(instr_addr_i, MemBase, MemWords);
    assign rvalid   = rsp.valid;
    // A response retiring this cycle frees a slot for a same-cycle grant.
    assign gnt      = instr_req_i & (wait_cnt_q >= gnt_wait_i)
                    & ((out_cnt_q < MaxOut) | rvalid);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GntIdle: if (instr_req_i && !gnt) state_d = GntWait;
            GntWait: if (gnt) state_d = GntIdle;
            default: state_d = GntIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= GntIdle;
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                wait_cnt_q <= '0;
            end else if (instr_req_i && wait_cnt_q != 2'd3) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end
            unique case ({gnt, rvalid})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    always_comb begin
        instr_gnt_o    = gnt;
        mem_req_o      = gnt & in_range;
        mem_addr_o     = AddrW'(win_offset(instr_addr_i, MemBase) >> 2);
        instr_rvalid_o = rsp.valid;
        instr_err_o    = rsp.err;
        instr_rdata_o  = rsp.rdata;
        busy_o         = instr_req_i | (out_cnt_q != '0);
    end

    cve2_imem_resp_pipe #(
        .RvalidLat(RvalidLat)
    ) u_resp_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (gnt),
        .in_err_i   (~in_range),
        .mem_rdata_i(mem_rdata_i),
        .rsp_o      (rsp)
    );

    a_req_held_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == GntWait) |-> instr_req_i);

    a_out_bounded: assert property (
        @(posedge clk_i) disable iff (!rst_ni) out_cnt_q <= MaxOut);

endmodule

// File: tb/tb_cve2_imem_responder.sv
// Scoreboard bench: three responder instances (latency 1, 3, 2) exercised one at a time.
module tb_cve2_imem_responder;
    import cve2_imem_pkg::*;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req       [NI];
    logic [31:0] addr      [NI];
    logic [1:0]  gwait     [NI];
    logic        gnt       [NI];
    logic        rvalid    [NI];
    logic [31:0] rdata     [NI];
    logic        err       [NI];
    logic        mem_req   [NI];
    logic [9:0]  mem_addr  [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];
    logic [31:0] sram      [1024];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cve2_imem_responder #(.MemBase(32'h0), .MemWords(1024), .RvalidLat(1), .MaxOutstanding(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
        .instr_err_o(err[0]), .gnt_wait_i(gwait[0]), .mem_req_o(mem_req[0]),
        .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0]));

    cve2_imem_responder #(.MemBase(32'h0), .MemWords(1024), .RvalidLat(3), .MaxOutstanding(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
        .instr_err_o(err[1]), .gnt_wait_i(gwait[1]), .mem_req_o(mem_req[1]),
        .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1]));

    cve2_imem_responder #(.MemBase(32'h0), .MemWords(1024), .RvalidLat(2), .MaxOutstanding(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
        .instr_err_o(err[2]), .gnt_wait_i(gwait[2]), .mem_req_o(mem_req[2]),
        .mem_addr_o(mem_addr[2]), .mem_rdata_i(mem_rdata[2]), .busy_o(busy[2]));

    // SRAM models return junk when not enabled so masking of error responses is visible.
    for (genvar g = 0; g < NI; g++) begin : g_sram
        always @(posedge clk) mem_rdata[g] <= mem_req[g] ? sram[mem_addr[g]] : 32'hBAD0_BAD0;
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic burst(input int k, input int n, input logic [31:0] a [4],
                         input logic [31:0] d [4], input logic e [4], input bit push,
                         output int gc [4]);
        int   start;
        bit   got;
        exp_t x;
        start  = cyc;
        req[k] = 1'b1;
        for (int i = 0; i < 4; i++) gc[i] = -1;
        for (int i = 0; i < n; i++) begin
            addr[k] = a[i];
            got     = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (gnt[k]) begin
                    got   = 1'b1;
                    gc[i] = cyc - start;
                    check("mem_req", 64'(mem_req[k]), 64'(!e[i]));
                    if (!e[i]) check("mem_addr", 64'(mem_addr[k]), 64'(a[i][11:2]));
                    if (push) begin
                        x.inst = k; x.cyc = cyc + lat_of(k); x.err = e[i]; x.data = d[i];
                        exp_q.push_back(x);
                    end
                end
                @(posedge clk); #1;
            end
            if (!got) check("gnt_timeout", 64'd0, 64'd1);
        end
        req[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every response is popped and compared, including its arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (rvalid[k]) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_rvalid inst %0d cyc %0d rdata %0h", k, cyc, rdata[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != k || e.cyc != cyc || err[k] !== e.err || rdata[k] !== e.data) begin
                        n_miss++;
                        $display("FAIL rsp: got inst %0d cyc %0d err %0b rdata %0h expected inst %0d cyc %0d err %0b rdata %0h",
                                 k, cyc, err[k], rdata[k], e.inst, e.cyc, e.err, e.data);
                    end
                end
            end else if (rst_n) begin
                n_vec++;
                if (err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                    n_miss++;
                    $display("FAIL idle_outputs inst %0d: got err %0b rdata %0h expected 0", k, err[k], rdata[k]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] av [4];
        logic [31:0] dv [4];
        logic        ev [4];
        int          gc [4];
        exp_t        x;

        for (int i = 0; i < 1024; i++) sram[i] = 32'hA500_0000 | i;
        sram[4] = 32'hDEAD_BEEF;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; addr[k] = '0; gwait[k] = 2'd0;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check("reset_outputs", 64'({gnt[k], rvalid[k], err[k], rdata[k], mem_req[k], busy[k]}), 64'd0);
        idle(1);

        // Single in-range fetch, zero wait states, latency 1.
        av = '{32'h0000_0010, 32'h0, 32'h0, 32'h0};
        dv = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        ev = '{1'b0, 1'b0, 1'b0, 1'b0};
        burst(0, 1, av, dv, ev, 1'b1, gc);
        check("gnt_same_cycle", 64'(gc[0]), 64'd0);
        idle(3);

        // Two wait states: grant on third request cycle, FSM in WAIT for two cycles.
        gwait[0] = 2'd2;
        req[0]   = 1'b1;
        addr[0]  = 32'h0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("wait_gnt", 64'(gnt[0]), 64'(t == 2));
            check("wait_state", 64'(u_dut0.state_q == GntWait), 64'(t != 0));
            if (gnt[0]) begin
                x.inst = 0; x.cyc = cyc + 1; x.err = 1'b0; x.data = 32'hA500_0000;
                exp_q.push_back(x);
            end
            @(posedge clk); #1;
        end
        req[0]   = 1'b0;
        gwait[0] = 2'd0;
        @(negedge clk);
        check("wait_state_idle", 64'(u_dut0.state_q == GntIdle), 64'd1);
        idle(3);

        // Window boundaries back-to-back: just past top, wrap below base, last word, unaligned.
        av = '{32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 32'h0000_0013};
        dv = '{32'h0, 32'h0, 32'hA500_03FF, 32'hDEAD_BEEF};
        ev = '{1'b1, 1'b1, 1'b0, 1'b0};
        burst(0, 4, av, dv, ev, 1'b1, gc);
        check("b2b_gnt1", 64'(gc[1]), 64'd1);
        check("b2b_gnt3", 64'(gc[3]), 64'd3);
        idle(4);

        // Latency 3, two outstanding: third grant waits for the first response.
        av = '{32'h0, 32'h4, 32'h8, 32'h0};
        dv = '{32'hA500_0000, 32'hA500_0001, 32'hA500_0002, 32'h0};
        ev = '{1'b0, 1'b0, 1'b0, 1'b0};
        burst(1, 3, av, dv, ev, 1'b1, gc);
        check("cap_gnt0", 64'(gc[0]), 64'd0);
        check("cap_gnt1", 64'(gc[1]), 64'd1);
        check("cap_gnt2", 64'(gc[2]), 64'd3);
        idle(8);

        // Reset one cycle after two grants drops both responses.
        av = '{32'h0, 32'h4, 32'h0, 32'h0};
        burst(2, 2, av, dv, ev, 1'b0, gc);
        check("rst_gnt1", 64'(gc[1]), 64'd1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 64'(busy[2]), 64'd0);
        idle(1);
        av = '{32'h8, 32'h0, 32'h0, 32'h0};
        dv = '{32'hA500_0002, 32'h0, 32'h0, 32'h0};
        burst(2, 1, av, dv, ev, 1'b1, gc);
        check("rst_new_gnt", 64'(gc[0]), 64'd0);
        idle(6);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cve2_imem_responder.md
CVE2_IMEM_RESPONDER -- requirements
Module: cve2_imem_responder

Interface
REQ-001 SHALL have parameter MemBase, default 32'h0000_0000, byte base address of the instruction memory window.
REQ-002 SHALL have parameter MemWords, default 1024, window size in 32-bit words (power of two, >= 2).
REQ-003 SHALL have parameter RvalidLat, default 1, cycles from grant to rvalid (legal 1..4).
REQ-004 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered requests (legal 1..RvalidLat+1).
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 instr_req_i  input  1  fetch request; held with stable address until granted.
REQ-008 instr_addr_i  input  32  byte address of the requested word.
REQ-009 instr_gnt_o  output  1  request accepted this cycle.
REQ-010 instr_rvalid_o  output  1  response valid this cycle, one per grant, in grant order.
REQ-011 instr_rdata_o  output  32  response word, valid with instr_rvalid_o.
REQ-012 instr_err_o  output  1  response error, valid with instr_rvalid_o.
REQ-013 gnt_wait_i  input  2  wait states: request cycles before grant is allowed (0..3).
REQ-014 mem_req_o  output  1  synchronous SRAM read enable.
REQ-015 mem_addr_o  output  $clog2(MemWords)  SRAM word index.
REQ-016 mem_rdata_i  input  32  SRAM read data, valid one cycle after mem_req_o.
REQ-017 busy_o  output  1  high while any request is outstanding or instr_req_i is pending ungranted.

Function
REQ-018 Grant FSM SHALL have states IDLE and WAIT; IDLE->WAIT on instr_req_i without grant; WAIT->IDLE on grant; no request in WAIT is a protocol violation (assertion).
REQ-019 A 2-bit wait counter SHALL clear on grant and increment each cycle instr_req_i is high without grant, saturating at 3.
REQ-020 instr_gnt_o SHALL be combinational: instr_req_i & (wait_cnt >= gnt_wait_i) & (outstanding < MaxOutstanding | rvalid this cycle).
REQ-021 With gnt_wait_i=0 and capacity available, grant SHALL occur in the same cycle instr_req_i rises.
REQ-022 A granted address SHALL be in-range when (addr - MemBase) < MemWords*4 (32-bit unsigned wrap); addr[1:0] are ignored (word aligned fetch).
REQ-023 On an in-range grant mem_req_o SHALL assert the same cycle with mem_addr_o = (addr - MemBase)[$clog2(MemWords)+1:2]; out-of-range grants SHALL NOT assert mem_req_o.
REQ-024 Each grant SHALL enter a latency pipeline of RvalidLat stages carrying {valid, err}; stage-1 data is mem_rdata_i; later stages register data.
REQ-025 instr_rvalid_o SHALL assert exactly RvalidLat cycles after the corresponding grant, independent of instr_req_i; responses never reorder or stall.
REQ-026 Out-of-range responses SHALL give instr_err_o=1 and instr_rdata_o=0; in-range give err=0 and SRAM data; both outputs SHALL be 0 when rvalid is low.
REQ-027 Outstanding counter SHALL +1 on grant, -1 on rvalid, unchanged when both occur in one cycle; never exceeds MaxOutstanding nor underflows.
REQ-028 Back-to-back grants every cycle SHALL be sustained when gnt_wait_i=0 and MaxOutstanding > RvalidLat-1... i.e. MaxOutstanding >= RvalidLat.

Reset
REQ-029 Reset SHALL clear FSM to IDLE, wait counter, outstanding counter and all pipeline valid bits; outputs gnt/rvalid/err/rdata/mem_req/busy read 0 until instr_req_i.
REQ-030 Reset asserted mid-transaction SHALL drop all outstanding responses; none appear after deassertion.
REQ-031 Pipeline data registers need no reset.

Structure
REQ-032 Address-window check function and the latency-pipeline entry struct {valid, err, rdata} SHALL live in package cve2_imem_pkg.
REQ-033 The latency pipeline SHALL be sub-module cve2_imem_resp_pipe (parameter RvalidLat); grant FSM and counters in the top.

Verification
REQ-034 gnt_wait_i=0, RvalidLat=1, req addr 0x0000_0010 for 1 cycle, SRAM word 4 = 0xDEAD_BEEF -> gnt same cycle, mem_addr_o=4, next cycle rvalid, rdata=0xDEAD_BEEF, err=0.
REQ-035 gnt_wait_i=2, req held at 0x0 -> gnt on third request cycle, FSM WAIT for 2 cycles, rvalid one cycle later.
REQ-036 MemWords=1024, req 0x0000_1000 -> gnt, mem_req_o=0, rvalid with err=1, rdata=0.
REQ-037 RvalidLat=3, MaxOutstanding=2, continuous req on 0x0,0x4,0x8 -> gnts cycles 0,1, third gnt cycle 3 (same cycle as first rvalid), rvalids in cycles 3,4,6 in order.
REQ-038 Reset asserted one cycle after two grants with RvalidLat=2 -> no rvalid after release, busy_o=0, first new req granted normally.
